// File: rtl/pipe_stage_chain.sv
// Parametrised chain of pipeline registers with per-stage stall/flush,
// registered occupancy and a saturating stall-cycle counter.
module pipe_stage_chain #(
    parameter  int STAGES = 3,
    parameter  int DATA_W = 32,
    parameter  int CTRL_W = 16,
    parameter  int CNT_W  = 16,
    localparam int OCC_W  = $clog2(STAGES + 1)
) (
    input  logic                     Clk,
    input  logic                     R,
    input  logic                     LE,
    input  logic                     in_valid,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [STAGES-1:0]        stall,
    input  logic [STAGES-1:0]        flush,
    output logic                     in_ready,
    output logic [STAGES-1:0]        st_valid,
    output logic [STAGES*CTRL_W-1:0] st_ctrl,
    output logic [STAGES*DATA_W-1:0] st_data,
    output logic [OCC_W-1:0]         occupancy,
    output logic [CNT_W-1:0]         stall_cnt
);

    logic [STAGES-1:0] valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q [STAGES];
    logic [CTRL_W-1:0] ctrl_d [STAGES];
    logic [DATA_W-1:0] data_q [STAGES];
    logic [DATA_W-1:0] data_d [STAGES];
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] prev_stall;
    logic [STAGES-1:0] src_valid;
    logic [CTRL_W-1:0] src_ctrl [STAGES];
    logic [DATA_W-1:0] src_data [STAGES];

    // A stall anywhere downstream freezes every stage upstream of it.
    always_comb begin
        logic acc;
        acc  = 1'b0;
        hold = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc     = acc | stall[k];
            hold[k] = acc;
        end
    end

    always_comb begin
        prev_stall    = '0;
        src_valid[0]  = in_valid;
        src_ctrl[0]   = in_ctrl;
        src_data[0]   = in_data;
        for (int k = 1; k < STAGES; k++) begin
            prev_stall[k] = stall[k-1];
            src_valid[k]  = valid_q[k-1];
            src_ctrl[k]   = ctrl_q[k-1];
            src_data[k]   = data_q[k-1];
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (LE) begin
            for (int k = 0; k < STAGES; k++) begin
                if (flush[k] || (!hold[k] && prev_stall[k])) begin
                    valid_d[k] = 1'b0;
                    ctrl_d[k]  = '0;
                    data_d[k]  = '0;
                end else if (!hold[k]) begin
                    // Bubbles never carry live control; data rides along untouched.
                    valid_d[k] = src_valid[k];
                    ctrl_d[k]  = src_valid[k] ? src_ctrl[k] : '0;
                    data_d[k]  = src_data[k];
                end
            end
        end
    end

    always_comb begin
        occ_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ_d = occ_d + OCC_W'(valid_d[k]);
        end
        cnt_d = cnt_q;
        if (LE && (|stall) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so all stages update from the same pre-edge values.
        if (!R) begin
            valid_q <= '0;
            occ_q   <= '0;
            cnt_q   <= '0;
            // NOTE: the stage arrays are ordinary registers and must read as zero after reset, so they are cleared too.
            for (int k = 0; k < STAGES; k++) begin
                ctrl_q[k] <= '0;
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            occ_q   <= occ_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = R & LE & ~hold[0];
    assign st_valid  = valid_q;
    assign occupancy = occ_q;
    assign stall_cnt = cnt_q;

    for (genvar g = 0; g < STAGES; g++) begin : g_pack
        assign st_ctrl[g*CTRL_W +: CTRL_W] = ctrl_q[g];
        assign st_data[g*DATA_W +: DATA_W] = data_q[g];
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain: a slot-level model predicts each edge,
// monitors compare registered outputs and in_ready against queued expectations.
module tb_pipe_stage_chain;

    localparam int STAGES = 3;
    localparam int DATA_W = 32;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 16;
    localparam int OCC_W  = 2;

    logic                     clk = 1'b0;
    logic                     R, LE, in_valid;
    logic [CTRL_W-1:0]        in_ctrl;
    logic [DATA_W-1:0]        in_data;
    logic [STAGES-1:0]        stall, flush;
    logic                     in_ready;
    logic [STAGES-1:0]        st_valid;
    logic [STAGES*CTRL_W-1:0] st_ctrl;
    logic [STAGES*DATA_W-1:0] st_data;
    logic [OCC_W-1:0]         occupancy;
    logic [CNT_W-1:0]         stall_cnt;

    logic                     s_in_ready;
    logic [STAGES-1:0]        s_st_valid;
    logic [STAGES*CTRL_W-1:0] s_st_ctrl;
    logic [STAGES*DATA_W-1:0] s_st_data;
    logic [OCC_W-1:0]         s_occupancy;
    logic [1:0]               s_stall_cnt;

    always #5 clk = ~clk;

    pipe_stage_chain #(.STAGES(STAGES), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) u_dut (
        .Clk(clk), .R(R), .LE(LE), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
        .stall(stall), .flush(flush), .in_ready(in_ready), .st_valid(st_valid),
        .st_ctrl(st_ctrl), .st_data(st_data), .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_chain #(.STAGES(STAGES), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(2)) u_small (
        .Clk(clk), .R(R), .LE(LE), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
        .stall(stall), .flush(flush), .in_ready(s_in_ready), .st_valid(s_st_valid),
        .st_ctrl(s_st_ctrl), .st_data(s_st_data), .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
    );

    typedef struct {
        logic [STAGES-1:0]        valid;
        logic [STAGES*CTRL_W-1:0] ctrl;
        logic [STAGES*DATA_W-1:0] data;
        logic [OCC_W-1:0]         occ;
        logic [CNT_W-1:0]         cnt;
        logic [1:0]               cnt_s;
    } exp_t;

    exp_t exp_q [$];
    logic rdy_q [$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: one slot per stage plus an unbounded stall count.
    bit                m_valid [STAGES];
    logic [CTRL_W-1:0] m_ctrl  [STAGES];
    logic [DATA_W-1:0] m_data  [STAGES];
    int unsigned       m_cnt;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic le, input logic v, input logic [CTRL_W-1:0] c,
                        input logic [DATA_W-1:0] d, input logic [STAGES-1:0] st, input logic [STAGES-1:0] fl);
        bit                nv [STAGES];
        logic [CTRL_W-1:0] nc [STAGES];
        logic [DATA_W-1:0] nd [STAGES];
        int                top;
        exp_t              e;
        @(negedge clk);
        R = r; LE = le; in_valid = v; in_ctrl = c; in_data = d; stall = st; flush = fl;
        rdy_q.push_back(r && le && (st == '0));
        nv = m_valid; nc = m_ctrl; nd = m_data;
        if (!r) begin
            for (int k = 0; k < STAGES; k++) begin nv[k] = 0; nc[k] = '0; nd[k] = '0; end
            m_cnt = 0;
        end else if (le) begin
            // Everything up to the furthest stalled stage freezes, the slot after it empties,
            // the rest shifts one place; flushed slots empty regardless.
            top = -1;
            for (int k = 0; k < STAGES; k++) if (st[k]) top = k;
            if (top >= 0) m_cnt++;
            for (int k = 0; k < STAGES; k++) begin
                if (k <= top) begin
                end else if (top >= 0 && k == top + 1) begin
                    nv[k] = 0; nc[k] = '0; nd[k] = '0;
                end else if (k == 0) begin
                    nv[k] = v; nc[k] = v ? c : '0; nd[k] = d;
                end else begin
                    nv[k] = m_valid[k-1]; nc[k] = m_ctrl[k-1]; nd[k] = m_data[k-1];
                end
            end
            for (int k = 0; k < STAGES; k++)
                if (fl[k]) begin nv[k] = 0; nc[k] = '0; nd[k] = '0; end
        end
        m_valid = nv; m_ctrl = nc; m_data = nd;
        e.occ = '0;
        for (int k = 0; k < STAGES; k++) begin
            e.valid[k] = m_valid[k];
            e.ctrl[k*CTRL_W +: CTRL_W] = m_ctrl[k];
            e.data[k*DATA_W +: DATA_W] = m_data[k];
            if (m_valid[k]) e.occ = e.occ + 1'b1;
        end
        e.cnt   = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
        e.cnt_s = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic rand_step(input int reset_odds, input int le_odds);
        logic [STAGES-1:0] st, fl;
        st = 3'($urandom) & 3'($urandom) & 3'($urandom);
        fl = 3'($urandom) & 3'($urandom) & 3'($urandom) & 3'($urandom);
        step(($urandom % reset_odds) != 0, ($urandom % le_odds) != 0, 1'($urandom),
             16'($urandom), $urandom, st, fl);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("st_valid",  st_valid,  e.valid);
                check("st_ctrl",   st_ctrl,   e.ctrl);
                check("st_data",   st_data,   e.data);
                check("occupancy", occupancy, e.occ);
                check("stall_cnt", stall_cnt, e.cnt);
                check("stall_cnt_w2", s_stall_cnt, e.cnt_s);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rdy_q.size() > 0) check("in_ready", in_ready, rdy_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        R = 1'b0; LE = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; stall = '0; flush = '0;
        m_cnt = 0;
        for (int k = 0; k < STAGES; k++) begin m_valid[k] = 0; m_ctrl[k] = '0; m_data[k] = '0; end

        repeat (2) step(0, 1, 0, '0, '0, '0, '0);
        repeat (20) rand_step(1000, 1000);
        repeat (2) step(0, 1, 1, 16'hFFFF, 32'hFFFF_FFFF, 3'b111, 3'b000);
        repeat (3) step(1, 1, 1, 16'h1234, 32'hA5A5_0001, '0, '0);

        // Stream with a two-cycle stall on stage 1; the source re-presents until accepted.
        idx = 0;
        for (int i = 0; i < 10; i++) begin
            logic [STAGES-1:0] st;
            st = (i == 3 || i == 4) ? 3'b010 : 3'b000;
            step(1, 1, 1, 16'(16'h0100 + idx), 32'hD000_0000 + 32'(idx), st, '0);
            if (st == '0) idx++;
        end

        repeat (3) step(1, 1, 1, 16'h00F0, 32'h0F0F_0000 + 32'($urandom_range(255)), '0, '0);
        step(1, 1, 1, 16'h00F1, 32'h0F0F_1111, 3'b000, 3'b011);

        repeat (3) step(1, 1, 1, 16'h00E0, 32'h0E0E_0000 + 32'($urandom_range(255)), '0, '0);
        step(1, 1, 1, 16'h00E1, 32'h0E0E_1111, 3'b010, 3'b010);

        step(1, 0, 1, 16'h0077, 32'h7777_0000, 3'b101, 3'b000);
        step(1, 0, 1, 16'h0077, 32'h7777_0001, 3'b000, 3'b001);
        step(1, 0, 1, 16'h0077, 32'h7777_0002, 3'b010, 3'b000);

        step(0, 1, 0, '0, '0, '0, '0);
        repeat (5) step(1, 1, 1, 16'h0055, 32'h5555_5555, 3'b100, 3'b000);

        step(0, 1, 1, 16'h0066, 32'h6666_6666, 3'b100, 3'b000);
        repeat (3) step(1, 1, 1, 16'h0066, 32'h6666_6667, 3'b100, 3'b000);

        repeat (400) rand_step(50, 8);
        repeat (2) step(1, 1, 0, '0, '0, '0, '0);

        @(posedge clk);
        @(posedge clk);
        #2;
        check("drain", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
